// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter for the 1-bit framebuffer write port: each grant captures a word and
// serializes it MSB-first into consecutive addresses, one bit per clock.
module fb_write_arbiter #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [WORD_WIDTH-1:0] din0,
    input  logic [WORD_WIDTH-1:0] din1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  done0,
    output logic                  done1,
    output logic                  wr_data,
    output logic [ADDR_WIDTH-1:0] wr_address,
    output logic                  wr_en,
    output logic                  busy
);

    localparam int unsigned CntWidth = $clog2(WORD_WIDTH);
    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(WORD_WIDTH - 1);
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
    localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

    state_e                state_q;
    logic [WORD_WIDTH-2:0] buf_q;
    logic [CntWidth-1:0]   cnt_q;
    logic                  owner_q;
    logic                  last_q;
    logic                  ack0_q, ack1_q, done0_q, done1_q;
    logic                  wr_data_q, wr_en_q, busy_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;

    logic                  grant1;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WORD_WIDTH-1:0] sel_din;

    // Requester 1 wins alone, or on a tie when requester 0 was granted last.
    assign grant1   = req1 && (!req0 || !last_q);
    assign sel_addr = grant1 ? addr1 : addr0;
    assign sel_din  = grant1 ? din1 : din0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            buf_q     <= '0;
            cnt_q     <= '0;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            wr_data_q <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req0 || req1) begin
                        owner_q   <= grant1;
                        buf_q     <= sel_din[WORD_WIDTH-2:0];
                        wr_data_q <= sel_din[WORD_WIDTH-1];
                        wr_addr_q <= sel_addr;
                        wr_en_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        ack0_q    <= !grant1;
                        ack1_q    <= grant1;
                        state_q   <= StWrite;
                    end
                end
                StWrite: begin
                    buf_q     <= {buf_q[WORD_WIDTH-3:0], 1'b0};
                    wr_addr_q <= wr_addr_q + AddrOne;
                    cnt_q     <= cnt_q + CntOne;
                    if (cnt_q == LastCnt) begin
                        wr_en_q   <= 1'b0;
                        wr_data_q <= 1'b0;
                        done0_q   <= !owner_q;
                        done1_q   <= owner_q;
                        last_q    <= owner_q;
                        state_q   <= StDone;
                    end else begin
                        wr_data_q <= buf_q[WORD_WIDTH-2];
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign done0      = done0_q;
    assign done1      = done1_q;
    assign wr_data    = wr_data_q;
    assign wr_address = wr_addr_q;
    assign wr_en      = wr_en_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: directed scenarios then random traffic, every cycle compared
// against a burst-timeline model (cycle k of a burst determines all outputs).
module tb_fb_write_arbiter;

    localparam int AW = 12;
    localparam int WW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic [WW-1:0] din0, din1;
    logic          ack0, ack1, done0, done1, wr_data, wr_en, busy;
    logic [AW-1:0] wr_address;

    int checks = 0;
    int errors = 0;

    // Model: k = 0 idle, 1..WW write cycles, WW+1 done cycle.
    int            m_k = 0;
    int            m_owner = 0;
    int            m_last = 1;
    int            m_base = 0;
    logic [WW-1:0] m_word = '0;

    fb_write_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .addr0      (addr0),
        .addr1      (addr1),
        .din0       (din0),
        .din1       (din1),
        .ack0       (ack0),
        .ack1       (ack1),
        .done0      (done0),
        .done1      (done1),
        .wr_data    (wr_data),
        .wr_address (wr_address),
        .wr_en      (wr_en),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_k = 0;
            m_last = 1;
        end else if (m_k == 0) begin
            if (req0 || req1) begin
                if (req0 && req1) m_owner = (m_last == 0) ? 1 : 0;
                else m_owner = req1 ? 1 : 0;
                m_base = m_owner ? int'(addr1) : int'(addr0);
                m_word = m_owner ? din1 : din0;
                m_last = m_owner;
                m_k = 1;
            end
        end else if (m_k == WW + 1) begin
            m_k = 0;
        end else begin
            m_k++;
        end
    endtask

    task automatic compare();
        logic en_e, data_e;
        en_e = (m_k >= 1 && m_k <= WW);
        data_e = 1'b0;
        if (en_e) data_e = m_word[WW-m_k];
        chk("wr_en", 32'(wr_en), 32'(en_e));
        chk("wr_data", 32'(wr_data), 32'(data_e));
        chk("busy", 32'(busy), 32'(m_k >= 1));
        chk("ack0", 32'(ack0), 32'(m_k == 1 && m_owner == 0));
        chk("ack1", 32'(ack1), 32'(m_k == 1 && m_owner == 1));
        chk("done0", 32'(done0), 32'(m_k == WW + 1 && m_owner == 0));
        chk("done1", 32'(done1), 32'(m_k == WW + 1 && m_owner == 1));
        if (en_e) chk("wr_address", 32'(wr_address), 32'((m_base + m_k - 1) % (1 << AW)));
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        compare();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        addr0 = '0;
        addr1 = '0;
        din0 = '0;
        din1 = '0;
        steps(2);
        chk("reset_addr", 32'(wr_address), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);

        // Single request from requester 0.
        reset = 1'b0;
        req0 = 1'b1;
        addr0 = 12'h010;
        din0 = 32'hA500_0001;
        step();
        chk("single_ack0", 32'(ack0), 32'h1);
        chk("single_addr", 32'(wr_address), 32'h010);
        chk("single_bit31", 32'(wr_data), 32'h1);
        req0 = 1'b0;
        steps(WW - 1);
        chk("single_last_addr", 32'(wr_address), 32'h02F);
        chk("single_last_bit", 32'(wr_data), 32'h1);
        step();
        chk("single_done0", 32'(done0), 32'h1);
        steps(3);

        // Simultaneous requests held, then round-robin over several bursts.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        addr0 = 12'h000;
        din0 = 32'hFFFF_FFFF;
        addr1 = 12'h100;
        din1 = 32'h0000_0000;
        step();
        chk("sim_first_ack0", 32'(ack0), 32'h1);
        steps(WW + 1);
        chk("sim_gap_busy", 32'(busy), 32'h0);
        step();
        chk("sim_second_ack1", 32'(ack1), 32'h1);
        chk("sim_second_addr", 32'(wr_address), 32'h100);
        steps(4 * (WW + 2));
        req0 = 1'b0;
        req1 = 1'b0;
        steps(WW + 2);

        // Address wrap on requester 1.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req1 = 1'b1;
        addr1 = 12'hFF0;
        din1 = 32'h0000_FFFF;
        step();
        req1 = 1'b0;
        steps(16);
        chk("wrap_addr0", 32'(wr_address), 32'h000);
        chk("wrap_bit", 32'(wr_data), 32'h1);
        steps(WW + 2);

        // Reset in the middle of a burst.
        req0 = 1'b1;
        addr0 = 12'h300;
        din0 = 32'h1234_5678;
        step();
        req0 = 1'b0;
        steps(9);
        reset = 1'b1;
        step();
        chk("midrst_en", 32'(wr_en), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        step();
        chk("midrst_ack0", 32'(ack0), 32'h1);
        req0 = 1'b0;
        req1 = 1'b0;
        steps(WW + 2);

        // One-cycle request still produces a full burst.
        req0 = 1'b1;
        addr0 = 12'h200;
        din0 = 32'hDEAD_BEEF;
        step();
        req0 = 1'b0;
        steps(WW);
        chk("drop_done0", 32'(done0), 32'h1);
        steps(40);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            req0 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 2) != 0);
            addr0 = AW'($urandom);
            addr1 = AW'($urandom);
            din0 = $urandom;
            din1 = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
